// File: rtl/utlb_pkg.sv
// utlb shared types: FSM state encoding and the micro-TLB entry layout.
package utlb_pkg;

  localparam int VAW   = 64;
  localparam int PAW   = 32;
  localparam int VPNW  = 52;
  localparam int PFNW  = 20;
  localparam int ASIDW = 8;
  localparam int OFFW  = 12;

  typedef enum logic [1:0] {
    UTLB_IDLE,
    UTLB_LOOKUP,
    UTLB_DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [VPNW-1:0]  vpn;
    logic [ASIDW-1:0] asid;
    logic [PFNW-1:0]  pfn;
    logic             cache;
    logic             wok;
  } entry_t;

  function automatic logic [PAW-1:0] mkpa(
    input logic [PFNW-1:0] pfn,
    input logic [OFFW-1:0] off
  );
    return {pfn, off};
  endfunction

endpackage

// File: rtl/utlb_cam.sv
// utlb entry array: parallel compare, one-hot hit vector, pfn/cache mux
// and a single write port that also drops any stale copy of the same page.
module utlb_cam
  import utlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phi2,
  input  logic             flush,
  input  logic             we,
  input  logic [IDXW-1:0]  widx,
  input  entry_t           wdata,
  input  logic [VPNW-1:0]  vpn,
  input  logic [ASIDW-1:0] asid,
  input  logic             wr,
  output logic             hit,
  output logic [PFNW-1:0]  pfn,
  output logic             cache
);

  entry_t ent [ENTRIES];
  logic [ENTRIES-1:0] hitv;

  always_comb begin
    hitv  = '0;
    pfn   = '0;
    cache = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      hitv[i] = ent[i].valid
             && (ent[i].vpn == vpn)
             && (ent[i].asid == asid)
             && (!wr || ent[i].wok);
      if (hitv[i]) begin
        pfn   = pfn | ent[i].pfn;
        cache = cache | ent[i].cache;
      end
    end
    hit = |hitv;
  end

  // A store refill of a page held read-only must not leave two copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        ent[i].valid <= 1'b0;
    end else if (phi2) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush)
          ent[i].valid <= 1'b0;
        else if (we) begin
          if (IDXW'(i) == widx)
            ent[i] <= wdata;
          else if (ent[i].vpn == wdata.vpn
                && ent[i].asid == wdata.asid)
            ent[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/utlb.sv
// utlb: per-port micro-TLB with joint TLB refill FSM.
// Optional hit/miss counters when UTLB_PERF_EN is defined.
module utlb
  import utlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phi2,
  input  logic             req,
  input  logic [VAW-1:0]   va,
  input  logic             wr,
  input  logic [ASIDW-1:0] asid,
  input  logic             flush,
  output logic             stall,
  output logic [PAW-1:0]   pa,
  output logic             cache,
  output logic             fault,
  output logic             miss,
  output logic             ade,
  output logic             inval,
  output logic             mod,
  output logic             jtlbreq,
  output logic [VAW-1:0]   jtlbva,
  output logic             jtlbwr,
  input  logic [PAW-1:0]   jtlbpa,
  input  logic             jtlbcache,
  input  logic             jtlbmiss,
  input  logic             jtlbade,
  input  logic             jtlbinval,
  input  logic             jtlbmod
`ifdef UTLB_PERF_EN
  ,
  output logic [31:0]      hitcnt,
  output logic [31:0]      misscnt
`endif
);

  state_t          state;
  logic [VAW-1:0]  lva;
  logic            lwr;
  logic [IDXW-1:0] ptr;
  logic            hit;
  logic [PFNW-1:0] hpfn;
  logic            anycause;
  logic            we;
  entry_t          wdata;
  logic            unused_palow;

  assign unused_palow = ^jtlbpa[OFFW-1:0];

  assign anycause = jtlbmiss | jtlbade | jtlbinval | jtlbmod;
  assign we = (state == UTLB_LOOKUP) && !flush && !anycause;

  always_comb begin
    wdata       = '0;
    wdata.valid = 1'b1;
    wdata.vpn   = lva[VAW-1:OFFW];
    wdata.asid  = asid;
    wdata.pfn   = jtlbpa[PAW-1:OFFW];
    wdata.cache = jtlbcache;
    wdata.wok   = lwr;
  end

  utlb_cam #(
    .ENTRIES(ENTRIES),
    .IDXW   (IDXW)
  ) u_cam (
    .clk  (clk),
    .rst  (rst),
    .phi2 (phi2),
    .flush(flush),
    .we   (we),
    .widx (ptr),
    .wdata(wdata),
    .vpn  (va[VAW-1:OFFW]),
    .asid (asid),
    .wr   (wr),
    .hit  (hit),
    .pfn  (hpfn),
    .cache(cache)
  );

  assign pa      = mkpa(hpfn, va[OFFW-1:0]);
  assign jtlbreq = (state == UTLB_LOOKUP);
  assign jtlbwr  = (state == UTLB_LOOKUP) && lwr;
  assign jtlbva  = lva;
  assign fault   = (state == UTLB_DONE)
                && (miss | ade | inval | mod);

  always_comb begin
    stall = 1'b0;
    unique case (1'b1)
      state == UTLB_IDLE:   stall = req && !hit;
      state == UTLB_LOOKUP: stall = 1'b1;
      default:              stall = 1'b0;
    endcase
  end

  // Flush during LOOKUP abandons the refill; the held req retries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UTLB_IDLE;
      lva   <= '0;
      lwr   <= 1'b0;
      ptr   <= '0;
      miss  <= 1'b0;
      ade   <= 1'b0;
      inval <= 1'b0;
      mod   <= 1'b0;
    end else if (phi2) begin
      unique case (state)
        UTLB_IDLE: begin
          if (req && !hit) begin
            lva   <= va;
            lwr   <= wr;
            state <= UTLB_LOOKUP;
          end
        end
        UTLB_LOOKUP: begin
          if (flush) begin
            state <= UTLB_IDLE;
          end else begin
            if (anycause) begin
              miss  <= jtlbmiss;
              ade   <= jtlbade;
              inval <= jtlbinval;
              mod   <= jtlbmod;
            end else begin
              ptr <= ptr + 1'b1;
            end
            state <= UTLB_DONE;
          end
        end
        UTLB_DONE: begin
          miss  <= 1'b0;
          ade   <= 1'b0;
          inval <= 1'b0;
          mod   <= 1'b0;
          state <= UTLB_IDLE;
        end
        default: state <= UTLB_IDLE;
      endcase
    end
  end

`ifdef UTLB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hitcnt  <= '0;
      misscnt <= '0;
    end else if (phi2 && state == UTLB_IDLE && req) begin
      if (hit)
        hitcnt <= hitcnt + 32'd1;
      else
        misscnt <= misscnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/utlb.md
Name: utlb

Overview:
- Small fully associative micro-TLB in front of the joint TLB, one instance per port (instruction fetch and data access).
- Translates a 64-bit VA to a 32-bit PA with a zero-cycle lookup on a hit.
- On a miss it issues one request to the joint TLB, sends any exception back to the pipeline, and fills an entry when the translation succeeds.
- Acts as the sole driver of the joint TLB request/VA/write lines for its port.

Parameters:
- ENTRIES, 4, number of entries; power of 2, 2..16.
- IDXW, $clog2(ENTRIES), replacement pointer width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- phi2  in  1  phase enable; all state updates occur only on clk edges with phi2=1.
- req  in  1  translation request, held stable until stall=0.
- va  in  64  virtual address.
- wr  in  1  access is a store.
- asid  in  8  current ASID (EntryHi[7:0]).
- flush  in  1  invalidate all entries (tlbwi/tlbwr/ASID write/mode change).
- stall  out  1  pipeline must hold; the result is not yet valid.
- pa  out  32  physical address, valid when req && !stall && !fault.
- cache  out  1  access is cacheable.
- fault  out  1  exception; cause given by miss/ade/inval/mod.
- miss, ade, inval, mod  out  1 each  registered copies of the joint TLB cause bits.
- jtlbreq  out  1  request to the joint TLB.
- jtlbva  out  64  VA to the joint TLB.
- jtlbwr  out  1  store flag to the joint TLB.
- jtlbpa  in  32  joint TLB PA, valid in the same cycle as jtlbreq.
- jtlbcache, jtlbmiss, jtlbade, jtlbinval, jtlbmod  in  1 each  joint TLB results, combinational from jtlbreq.

Behaviour:
- Entry fields: valid, vpn = va[63:12], asid[7:0], pfn[19:0], cache, wok (write permitted).
- Hit conditions (all required):
  - valid;
  - vpn == va[63:12];
  - entry asid == asid;
  - !wr || wok.
- A store to an entry with wok=0 is a miss. This forces the joint TLB to raise mod when it applies.
- Result on a hit: pa = {pfn, va[11:0]}, same cycle; stall=0.
- Multiple hits cannot occur. The fill logic never inserts a vpn/asid pair that is already present.
- State machine, states IDLE, LOOKUP, DONE:
  - IDLE: if req && !hit → stall=1. On phi2, latch va and wr, then go to LOOKUP.
  - LOOKUP: jtlbreq=1, jtlbva=latched va, jtlbwr=latched wr, stall=1. On phi2:
    - If no jtlb cause bit is set: write the entry at the replacement pointer with valid=1 and pfn = jtlbpa[31:12]. Set wok=1 when wr=1. When wr=0, set wok=0, so a later store re-checks the dirty bit. Increment the pointer modulo ENTRIES.
    - If any cause bit is set: register the cause bits and write no entry.
    - Either way, go to DONE.
  - DONE: stall=0.
    - Fault case: fault=1 with the registered causes, pa=x.
    - Fill case: the entry now hits and supplies pa.
    - On phi2, return to IDLE and clear the registered causes.
- A req that changes va in IDLE while stall=1 is illegal; it is not checked.
- flush: on phi2 all valid bits clear. Flush in LOOKUP cancels the fill: state → IDLE, no causes are registered, and a hit is re-attempted afterwards. Flush in DONE clears entries, and the registered fault still reports.
- Simultaneous hit and flush in IDLE: the hit result is returned this cycle and entries clear at the edge.
- Reset: all valid=0, pointer=0, state=IDLE, causes=0. Outputs after reset: stall=0, fault=0, jtlbreq=0, jtlbwr=0, jtlbva=0, miss/ade/inval/mod=0. A reset mid-LOOKUP abandons the request.
- jtlbreq is never asserted outside LOOKUP.
- jtlbva is held at the latched va in every state. This avoids glitching the joint TLB compare logic.

Optional Feature:
- Macro: UTLB_PERF_EN.
- Defined:
  - Adds outputs hitcnt[31:0] and misscnt[31:0], both cleared by rst or flush-independent reset only.
  - hitcnt increments on phi2 in IDLE when req && hit.
  - misscnt increments on the IDLE→LOOKUP transition.
  - Both counters wrap at 2^32.
- Undefined: neither port exists and the logic is unchanged.

Decomposition:
- Shared package: state encoding (UTLB_IDLE/LOOKUP/DONE) and an entry struct layout (valid, vpn, asid, pfn, cache, wok) with field widths.
- Natural sub-module: utlb_cam. It holds the entry array, the parallel compare, a one-hot hit vector and a mux to pfn/cache, and has a write port indexed by the pointer.
- The top level owns the FSM, the pointer and the joint TLB interface.

Test Plan:
1. After reset, req va=0x0000_0000_0040_1234 wr=0 → stall=1 for two phi2 cycles. jtlbreq=1 with jtlbva=va during LOOKUP. With jtlbpa=0x0123_4000, result pa=0x0123_4234 and fault=0. A repeat of the same access → stall=0 in the same cycle.
2. Fill 5 distinct pages with ENTRIES=4 → page 1 is evicted (pointer wraps 3→0). Accessing page 1 again → jtlbreq reasserts.
3. Load fills page P, then a store to P → miss. jtlbmod=1 → fault=1 and mod=1 in DONE, no fill. A following load to P → hit.
4. jtlbmiss=1 on a lookup → fault=1, miss=1 for one phi2 cycle, then IDLE with causes 0. The same VA retried → new LOOKUP, since no entry was written.
5. Fill an entry with asid=5, change asid to 6 without flush → miss. Assert flush in LOOKUP → no fill, no fault, and the FSM restarts.
6. Assert rst during LOOKUP → next cycle jtlbreq=0, stall=0, and all entries invalid.
